// File: rtl/keccak_round_ctrl.sv
// Slice-serial round scheduler for Keccak-f[1600]: LOAD, 24x(PAR, CHI), UNLOAD over 8 slices.
// Optional KECCAK_HALF_RND_EN adds a `half` input selecting 12-round (13..24) permutations.
module keccak_round_ctrl #(
  parameter int unsigned NSLICE = 8,
  parameter int unsigned NRND   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
`ifdef KECCAK_HALF_RND_EN
  input  logic       half,
`endif
  output logic       busy,
  output logic       done,
  output logic [4:0] rnd_cnt,
  output logic [2:0] sub_rnd_cnt,
  output logic       ld_en,
  output logic       par_en,
  output logic       chi_en,
  output logic       ul_en,
  output logic       par_clr
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] PAR    = 3'd2;
  localparam logic [2:0] CHI    = 3'd3;
  localparam logic [2:0] UNLOAD = 3'd4;

  logic [2:0] state_q, state_d;
  logic [2:0] s_q, s_d;
  logic [4:0] rnd_q, rnd_d;
  logic [4:0] first_rnd;
  logic       s_last;

`ifdef KECCAK_HALF_RND_EN
  logic half_q, half_d;

  assign first_rnd = half_q ? 5'(NRND / 2 + 1) : 5'd1;
`else
  assign first_rnd = 5'd1;
`endif

  assign s_last = (s_q == 3'(NSLICE - 1));

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    rnd_d   = rnd_q;
`ifdef KECCAK_HALF_RND_EN
    half_d  = half_q;
`endif
    case (state_q)
      IDLE: begin
        // start is accepted even while stall is high; stall only freezes active phases
        if (start) begin
          state_d = LOAD;
          s_d     = '0;
`ifdef KECCAK_HALF_RND_EN
          half_d  = half;
`endif
        end
      end
      LOAD: begin
        if (!stall) begin
          s_d = s_q + 3'd1;
          if (s_last) begin
            state_d = PAR;
            rnd_d   = first_rnd;
          end
        end
      end
      PAR: begin
        if (!stall) begin
          s_d = s_q + 3'd1;
          if (s_last) state_d = CHI;
        end
      end
      CHI: begin
        if (!stall) begin
          s_d = s_q + 3'd1;
          if (s_last) begin
            if (rnd_q == 5'(NRND)) begin
              state_d = UNLOAD;
              rnd_d   = '0;
            end else begin
              state_d = PAR;
              rnd_d   = rnd_q + 5'd1;
            end
          end
        end
      end
      UNLOAD: begin
        if (!stall) begin
          s_d = s_q + 3'd1;
          if (s_last) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
        rnd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      rnd_q   <= '0;
`ifdef KECCAK_HALF_RND_EN
      half_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      rnd_q   <= rnd_d;
`ifdef KECCAK_HALF_RND_EN
      half_q  <= half_d;
`endif
    end
  end

  // Strobes decode registered state; stall is the only combinational gate.
  assign busy        = (state_q != IDLE);
  assign rnd_cnt     = rnd_q;
  assign sub_rnd_cnt = s_q;
  assign ld_en       = (state_q == LOAD)   && !stall;
  assign par_en      = (state_q == PAR)    && !stall;
  assign chi_en      = (state_q == CHI)    && !stall;
  assign ul_en       = (state_q == UNLOAD) && !stall;
  assign par_clr     = (state_q == PAR)    && (s_q == '0) && !stall;
  assign done        = (state_q == UNLOAD) && s_last && !stall;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Scoreboard bench for keccak_round_ctrl: a beat-list reference model feeds a queue drained by a monitor.
// Define KECCAK_HALF_RND_EN for both files to exercise the 12-round mode.
module tb_keccak_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
`ifdef KECCAK_HALF_RND_EN
  logic       half = 1'b0;
`endif
  logic       busy, done;
  logic [4:0] rnd_cnt;
  logic [2:0] sub_rnd_cnt;
  logic       ld_en, par_en, chi_en, ul_en, par_clr;

  keccak_round_ctrl #(.NSLICE(8), .NRND(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stall      (stall),
`ifdef KECCAK_HALF_RND_EN
    .half       (half),
`endif
    .busy       (busy),
    .done       (done),
    .rnd_cnt    (rnd_cnt),
    .sub_rnd_cnt(sub_rnd_cnt),
    .ld_en      (ld_en),
    .par_en     (par_en),
    .chi_en     (chi_en),
    .ul_en      (ul_en),
    .par_clr    (par_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ld, par, chi, ul, pclr, dn;
    logic [4:0] rnd;
    logic [2:0] sub;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned left = 0;
  bit          flush = 1'b0;
  bit          exp_busy = 1'b0;
  bit          exp_beat = 1'b0;
  bit          mon_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  localparam int unsigned NONE = 32'hFFFF_FFFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic ld, par, chi, ul, pclr, dn,
                               input int unsigned rnd, input int unsigned sub);
    beat_t b;
    b = '{ld, par, chi, ul, pclr, dn, 5'(rnd), 3'(sub)};
    return b;
  endfunction

  // Whole permutation as an ordered list of beats: 8 loads, rounds of 8 PAR then 8 CHI, 8 unloads.
  task automatic push_perm(input bit h);
    int unsigned first;
    first = h ? 13 : 1;
    for (int unsigned s = 0; s < 8; s++) exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, s));
    for (int unsigned r = first; r <= 24; r++) begin
      for (int unsigned s = 0; s < 8; s++) exp_q.push_back(mk(0, 1, 0, 0, s == 0, 0, r, s));
      for (int unsigned s = 0; s < 8; s++) exp_q.push_back(mk(0, 0, 1, 0, 0, 0, r, s));
    end
    for (int unsigned s = 0; s < 8; s++) exp_q.push_back(mk(0, 0, 0, 1, 0, s == 7, 0, s));
    left = 16 + (25 - first) * 16;
  endtask

  task automatic step(input bit st, input bit stl, input bit r, input bit h);
    @(posedge clk);
    #1;
    if (flush) begin
      exp_q.delete();
      left  = 0;
      flush = 1'b0;
    end
    start = st;
    stall = stl;
    rst   = r;
`ifdef KECCAK_HALF_RND_EN
    half  = h;
`endif
    exp_busy = (left > 0);
    exp_beat = exp_busy && !stl;
    if (exp_beat) left--;
    if (!exp_busy && st && !r) push_perm(h);
    if (r) flush = 1'b1;
  endtask

  task automatic scen(input int unsigned len, input int unsigned stall_at, input int unsigned stall_len,
                      input int unsigned start2, input int unsigned rst_at, input bit h);
    for (int unsigned t = 0; t < len; t++)
      step((t == 0) || (t == start2),
           (stall_at != NONE) && (t >= stall_at) && (t < stall_at + stall_len),
           (t == rst_at), h);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      beat_t got;
      logic  any;
      got = '{ld_en, par_en, chi_en, ul_en, par_clr, done, rnd_cnt, sub_rnd_cnt};
      any = ld_en | par_en | chi_en | ul_en;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("beat_present", 32'(any), 32'(exp_beat));
      if (exp_beat) begin
        if (exp_q.size() == 0) chk("queue_underflow", 32'(1), 32'(0));
        else chk("beat", 32'(got), 32'(exp_q.pop_front()));
      end else if (exp_busy && exp_q.size() != 0) begin
        chk("stalled_hold", 32'(got), 32'(mk(0, 0, 0, 0, 0, 0, exp_q[0].rnd, exp_q[0].sub)));
      end else begin
        chk("idle_outputs", 32'(got), 32'(0));
      end
    end
  end

  initial begin
    bit h;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    mon_en = 1'b1;
    repeat (3) step(0, 1, 0, 0);
    scen(420, NONE, 0, 50, NONE, 0);
    scen(430, 100, 5, 450, NONE, 0);
    scen(620, NONE, 0, 205, 200, 0);
    scen(820, NONE, 0, 401, NONE, 0);
`ifdef KECCAK_HALF_RND_EN
    scen(230, NONE, 0, NONE, NONE, 1);
`endif
    for (int k = 0; k < 4000; k++) begin
`ifdef KECCAK_HALF_RND_EN
      h = 1'($urandom_range(0, 1));
`else
      h = 1'b0;
`endif
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2999) == 0, h);
    end
    repeat (500) step(0, 0, 0, 0);
    mon_en = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
